// File: rtl/alu_operand_flags_if.sv
// alu_operand_flags_if: control, bus and ALU signals around the operand/flags stage
interface alu_operand_flags_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] bus_in;
    logic             a_in;
    logic             a_out;
    logic             b_in;
    logic             alu_out;
    logic             fi;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;
    logic             alu_zero;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic [WIDTH-1:0] bus_out;
    logic             bus_out_en;
    logic             carry_flag;
    logic             zero_flag;
    logic             bus_conflict;
    modport master (
        output bus_in, a_in, a_out, b_in, alu_out, fi, alu_result, alu_overflow, alu_zero,
        input  port_a, port_b, bus_out, bus_out_en, carry_flag, zero_flag, bus_conflict
    );
    modport slave (
        input  bus_in, a_in, a_out, b_in, alu_out, fi, alu_result, alu_overflow, alu_zero,
        output port_a, port_b, bus_out, bus_out_en, carry_flag, zero_flag, bus_conflict
    );
endinterface

// File: rtl/alu_operand_flags.sv
// alu_operand_flags: ALU operand registers, flags latch and shared-bus drive arbitration
module alu_operand_flags #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                n_rst,
    alu_operand_flags_if.slave bus
);
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic             carry_q;
    logic             zero_q;
    logic             conflict_q;
    // operand registers load from the bus; A and B may load the same value together
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            reg_a <= '0;
            reg_b <= '0;
        end else begin
            if (bus.a_in) reg_a <= bus.bus_in;
            if (bus.b_in) reg_b <= bus.bus_in;
        end
    end
    // flags capture the ALU outputs of the operands present before this edge
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (bus.fi) begin
            carry_q <= bus.alu_overflow;
            zero_q  <= bus.alu_zero;
        end
    end
    // sticky record of both bus drivers requested in the same cycle
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) conflict_q <= 1'b0;
        else        conflict_q <= conflict_q | (bus.a_out & bus.alu_out);
    end
    // ALU result has priority over register A when both ask for the bus
    always_comb begin
        bus.bus_out    = bus.alu_out ? bus.alu_result : bus.a_out ? reg_a : '0;
        bus.bus_out_en = bus.alu_out | bus.a_out;
    end
    assign bus.port_a       = reg_a;
    assign bus.port_b       = reg_b;
    assign bus.carry_flag   = carry_q;
    assign bus.zero_flag    = zero_q;
    assign bus.bus_conflict = conflict_q;
endmodule

// File: tb/tb_alu_operand_flags.sv
// tb_alu_operand_flags: directed-vector bench with a behavioural adder/subtractor
module tb_alu_operand_flags;
    logic clk;
    logic n_rst;
    logic sub;
    int   vectors;
    int   miscompares;
    logic [8:0] alu_full;

    alu_operand_flags_if #(.WIDTH(8)) bus ();

    alu_operand_flags #(.WIDTH(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external combinational ALU: overflow is carry-out on add, borrow on sub
    always_comb begin
        alu_full         = sub ? ({1'b0, bus.port_a} - {1'b0, bus.port_b})
                               : ({1'b0, bus.port_a} + {1'b0, bus.port_b});
        bus.alu_result   = alu_full[7:0];
        bus.alu_overflow = alu_full[8];
        bus.alu_zero     = (alu_full[7:0] == 8'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        bus.bus_in = a; bus.a_in = 1'b1;
        tick();
        bus.a_in = 1'b0; bus.bus_in = b; bus.b_in = 1'b1;
        tick();
        bus.b_in = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) tick();
        n_rst = 1'b1;
        tick();
        vectors++; if (bus.port_a !== 8'd0) begin miscompares++; $display("FAIL reset_port_a: got %0d expected 0", bus.port_a); end
        vectors++; if (bus.port_b !== 8'd0) begin miscompares++; $display("FAIL reset_port_b: got %0d expected 0", bus.port_b); end
        vectors++; if (bus.carry_flag !== 1'b0) begin miscompares++; $display("FAIL reset_carry: got %b expected 0", bus.carry_flag); end
        vectors++; if (bus.zero_flag !== 1'b0) begin miscompares++; $display("FAIL reset_zero: got %b expected 0", bus.zero_flag); end
        vectors++; if (bus.bus_out_en !== 1'b0) begin miscompares++; $display("FAIL reset_bus_en: got %b expected 0", bus.bus_out_en); end
        vectors++; if (bus.bus_out !== 8'd0) begin miscompares++; $display("FAIL reset_bus_out: got %0d expected 0", bus.bus_out); end
        vectors++; if (bus.bus_conflict !== 1'b0) begin miscompares++; $display("FAIL reset_conflict: got %b expected 0", bus.bus_conflict); end
    endtask

    task automatic test_add();
        sub = 1'b0;
        load_ab(8'd10, 8'd20);
        vectors++; if (bus.port_a !== 8'd10) begin miscompares++; $display("FAIL add_port_a: got %0d expected 10", bus.port_a); end
        vectors++; if (bus.port_b !== 8'd20) begin miscompares++; $display("FAIL add_port_b: got %0d expected 20", bus.port_b); end
        bus.alu_out = 1'b1;
        #1;
        vectors++; if (bus.bus_out !== 8'd30) begin miscompares++; $display("FAIL add_bus_out: got %0d expected 30", bus.bus_out); end
        vectors++; if (bus.bus_out_en !== 1'b1) begin miscompares++; $display("FAIL add_bus_en: got %b expected 1", bus.bus_out_en); end
        bus.alu_out = 1'b0;
        bus.fi = 1'b1;
        tick();
        bus.fi = 1'b0;
        vectors++; if (bus.carry_flag !== 1'b0) begin miscompares++; $display("FAIL add_carry: got %b expected 0", bus.carry_flag); end
        vectors++; if (bus.zero_flag !== 1'b0) begin miscompares++; $display("FAIL add_zero: got %b expected 0", bus.zero_flag); end
    endtask

    task automatic test_flags();
        sub = 1'b0;
        load_ab(8'd200, 8'd100);
        bus.alu_out = 1'b1;
        #1;
        vectors++; if (bus.bus_out !== 8'd44) begin miscompares++; $display("FAIL ovf_bus_out: got %0d expected 44", bus.bus_out); end
        bus.alu_out = 1'b0;
        bus.fi = 1'b1;
        tick();
        bus.fi = 1'b0;
        vectors++; if (bus.carry_flag !== 1'b1) begin miscompares++; $display("FAIL ovf_carry: got %b expected 1", bus.carry_flag); end
        vectors++; if (bus.zero_flag !== 1'b0) begin miscompares++; $display("FAIL ovf_zero: got %b expected 0", bus.zero_flag); end
        sub = 1'b1;
        load_ab(8'd200, 8'd201);
        bus.alu_out = 1'b1;
        #1;
        vectors++; if (bus.bus_out !== 8'd255) begin miscompares++; $display("FAIL borrow_bus_out: got %0d expected 255", bus.bus_out); end
        bus.alu_out = 1'b0;
        bus.fi = 1'b1;
        tick();
        bus.fi = 1'b0;
        vectors++; if (bus.carry_flag !== 1'b1) begin miscompares++; $display("FAIL borrow_carry: got %b expected 1", bus.carry_flag); end
        load_ab(8'd5, 8'd5);
        vectors++; if (bus.carry_flag !== 1'b1) begin miscompares++; $display("FAIL flags_hold: got %b expected 1", bus.carry_flag); end
        bus.fi = 1'b1;
        tick();
        bus.fi = 1'b0;
        vectors++; if (bus.carry_flag !== 1'b0) begin miscompares++; $display("FAIL eq_carry: got %b expected 0", bus.carry_flag); end
        vectors++; if (bus.zero_flag !== 1'b1) begin miscompares++; $display("FAIL eq_zero: got %b expected 1", bus.zero_flag); end
    endtask

    task automatic test_fi_with_load();
        sub = 1'b1;
        load_ab(8'd6, 8'd5);
        bus.fi = 1'b1;
        tick();
        bus.fi = 1'b0;
        vectors++; if (bus.zero_flag !== 1'b0) begin miscompares++; $display("FAIL pre_zero: got %b expected 0", bus.zero_flag); end
        bus.bus_in = 8'd5; bus.a_in = 1'b1;
        tick();
        bus.bus_in = 8'd7; bus.fi = 1'b1;
        tick();
        bus.a_in = 1'b0; bus.fi = 1'b0;
        vectors++; if (bus.zero_flag !== 1'b1) begin miscompares++; $display("FAIL simul_zero: got %b expected 1", bus.zero_flag); end
        vectors++; if (bus.port_a !== 8'd7) begin miscompares++; $display("FAIL simul_port_a: got %0d expected 7", bus.port_a); end
    endtask

    task automatic test_arbitration();
        sub = 1'b0;
        load_ab(8'd3, 8'd6);
        vectors++; if (bus.bus_conflict !== 1'b0) begin miscompares++; $display("FAIL arb_pre_conflict: got %b expected 0", bus.bus_conflict); end
        bus.a_out = 1'b1;
        #1;
        vectors++; if (bus.bus_out !== 8'd3) begin miscompares++; $display("FAIL arb_a_only: got %0d expected 3", bus.bus_out); end
        bus.alu_out = 1'b1;
        #1;
        vectors++; if (bus.bus_out !== 8'd9) begin miscompares++; $display("FAIL arb_both_out: got %0d expected 9", bus.bus_out); end
        vectors++; if (bus.bus_out_en !== 1'b1) begin miscompares++; $display("FAIL arb_both_en: got %b expected 1", bus.bus_out_en); end
        tick();
        bus.a_out = 1'b0; bus.alu_out = 1'b0;
        #1;
        vectors++; if (bus.bus_conflict !== 1'b1) begin miscompares++; $display("FAIL arb_conflict: got %b expected 1", bus.bus_conflict); end
        vectors++; if (bus.bus_out_en !== 1'b0) begin miscompares++; $display("FAIL arb_idle_en: got %b expected 0", bus.bus_out_en); end
        vectors++; if (bus.bus_out !== 8'd0) begin miscompares++; $display("FAIL arb_idle_out: got %0d expected 0", bus.bus_out); end
        repeat (10) tick();
        vectors++; if (bus.bus_conflict !== 1'b1) begin miscompares++; $display("FAIL arb_sticky: got %b expected 1", bus.bus_conflict); end
        n_rst = 1'b0;
        #1;
        vectors++; if (bus.bus_conflict !== 1'b0) begin miscompares++; $display("FAIL arb_reset: got %b expected 0", bus.bus_conflict); end
        tick();
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_async_reset();
        bus.bus_in = 8'h11; bus.a_in = 1'b1;
        tick();
        vectors++; if (bus.port_a !== 8'h11) begin miscompares++; $display("FAIL ar_preload: got %0h expected 11", bus.port_a); end
        bus.bus_in = 8'hAA;
        #2 n_rst = 1'b0;
        #1;
        vectors++; if (bus.port_a !== 8'd0) begin miscompares++; $display("FAIL ar_immediate: got %0h expected 0", bus.port_a); end
        #1 n_rst = 1'b1;
        #1;
        vectors++; if (bus.port_a !== 8'd0) begin miscompares++; $display("FAIL ar_released: got %0h expected 0", bus.port_a); end
        tick();
        bus.a_in = 1'b0;
        vectors++; if (bus.port_a !== 8'hAA) begin miscompares++; $display("FAIL ar_reload: got %0h expected aa", bus.port_a); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        n_rst = 1'b0; sub = 1'b0;
        bus.bus_in = '0; bus.a_in = 1'b0; bus.a_out = 1'b0; bus.b_in = 1'b0;
        bus.alu_out = 1'b0; bus.fi = 1'b0;
        test_reset();
        test_add();
        test_flags();
        test_fi_with_load();
        test_arbitration();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
